mdu_sched: RTL and testbench
============================

Name: mdu_sched

Overview:
- Issue/commit controller for the multiply-divide path in the E stage of the 5-stage MIPS pipeline.
- Accepts MDU instructions from E and launches them on a multi-cycle arithmetic unit through a start/done handshake.
- Enforces fixed architectural latencies and owns the architectural HI/LO registers.
- Generates the E-stage stall and handles exception/interrupt flush (req), including rollback of MTHI/MTLO and cancellation of in-flight operations.

Parameters:
- MUL_LAT, 5: minimum busy cycles for MULT/MULTU.
- DIV_LAT, 10: minimum busy cycles for DIV/DIVU.
- CW, 4: latency counter width; must hold DIV_LAT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  E-stage instruction valid
- e_op  in  6  MULT=0x15 MULTU=0x16 DIV=0x17 DIVU=0x18 MFHI=0x19 MFLO=0x1A MTHI=0x1B MTLO=0x1C; other codes are non-MDU
- e_rs  in  32  operand 1 / MT source
- e_rt  in  32  operand 2
- req  in  1  flush: the instruction in M and everything younger are cancelled this cycle
- unit_done  in  1  one-cycle pulse, unit result valid
- unit_hi, unit_lo  in  32 each  unit result
- unit_start  out  1  one-cycle launch pulse
- unit_op  out  2  0=MULT 1=MULTU 2=DIV 3=DIVU
- unit_a, unit_b  out  32 each  registered operands, stable from unit_start until done
- busy  out  1  state != IDLE
- stall_e  out  1  busy & e_valid & e_op is any of the 8 MDU codes
- rd_data  out  32  MFHI→HI, MFLO→LO, else 0 (combinational from architectural regs)
- hi, lo  out  32 each  architectural HI/LO

Behaviour:
- Reset: state IDLE; HI, LO, shadows, pending regs, counter and flags = 0; unit_start=0; unit_op=0; unit_a/b=0. Reset mid-operation abandons the op. The unit shares the reset, so no stray done is expected.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, issue:
  - Condition: e_valid & ~req & op ∈ {MULT, MULTU, DIV, DIVU}.
  - Next cycle: unit_start=1 for exactly one cycle; unit_op, unit_a, unit_b latched.
  - cnt = MUL_LAT or DIV_LAT; age=1; dz = (op is DIV/DIVU & e_rt==0); goto RUN.
- IDLE, MTHI/MTLO (e_valid & ~req): save old HI/LO into the shadow, write e_rs, set mt_age=1 (cleared the following cycle). No state change.
- RUN:
  - cnt decrements to 0 and saturates; age cleared after the first RUN cycle.
  - On unit_done: capture unit_hi/unit_lo into pending and set seen=1.
  - Commit when cnt==0 & (seen | unit_done):
    - HI/LO ← pending, or the same-cycle unit_hi/lo; skip the write if dz.
    - Goto IDLE; busy drops next cycle.
  - Minimum busy time is exactly the latency, even if done arrives early. Late done extends busy until done.
- RUN with req while age==1: the issuing instruction is being flushed.
  - Discard the result; HI/LO never written.
  - If unit_done is not seen and not present this cycle, goto DRAIN; otherwise goto IDLE.
  - req while age==0: the op has graduated; ignore req.
- DRAIN: busy=1; the next unit_done is discarded; goto IDLE.
- MT rollback: req while mt_age==1 restores HI/LO from the shadow the same edge.
- req in the same cycle as an E-stage MDU op: that op is flushed; no issue, no MT write.
- Stalls:
  - While busy, no issue or MT occurs; stall_e=1 for MDU ops, including MFHI/MFLO.
  - Non-MDU ops never stall.
- Arithmetic is the unit's job. The controller only commits or suppresses; divide-by-zero leaves HI/LO unchanged.
- unit_done in IDLE is ignored.

Test Plan:
- MULT rs=3 rt=0xFFFFFFFE, unit done at cycle 2 → unit_start 1 cycle; busy exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA visible the cycle busy falls; stall_e on a trailing MFLO until then; rd_data=0xFFFFFFFA.
- DIVU 7/2 with done at cycle 14 → busy 14 cycles; HI=1, LO=3. DIV rs=5 rt=0 → busy 10 cycles, HI/LO unchanged.
- DIV issued, req the next cycle, done at cycle 6 → DRAIN; busy until done; HI/LO unchanged; next MULT issues normally.
- MTHI 0x1234 (HI previously 0xAAAA), req the next cycle → HI=0xAAAA. Same stimulus without req → HI=0x1234.
- MULT with req on the same cycle as e_valid → no unit_start, busy stays 0. Reset asserted mid-RUN → IDLE, busy=0, HI=LO=0.

Source files
------------

// File: rtl/mdu_sched_if.sv
// Signal bundle between the E stage, the multi-cycle MDU arithmetic unit and the
// MDU issue/commit scheduler. The scheduler connects through the slave modport.
interface mdu_sched_if;
    logic        e_valid;
    logic [5:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        req;
    logic        unit_done;
    logic [31:0] unit_hi;
    logic [31:0] unit_lo;
    logic        unit_start;
    logic [1:0]  unit_op;
    logic [31:0] unit_a;
    logic [31:0] unit_b;
    logic        busy;
    logic        stall_e;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  e_valid, e_op, e_rs, e_rt, req, unit_done, unit_hi, unit_lo,
        output unit_start, unit_op, unit_a, unit_b, busy, stall_e, rd_data, hi, lo
    );

    modport master (
        output e_valid, e_op, e_rs, e_rt, req, unit_done, unit_hi, unit_lo,
        input  unit_start, unit_op, unit_a, unit_b, busy, stall_e, rd_data, hi, lo
    );
endinterface

// File: rtl/mdu_sched.sv
// E-stage issue/commit controller for the MIPS multiply-divide unit: launches ops,
// enforces fixed latencies, owns HI/LO and handles flush/rollback.
module mdu_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CW      = 4
) (
    input logic        clk,
    input logic        reset,
    mdu_sched_if.slave bus
);
    localparam logic [5:0] OP_MULT  = 6'h15;
    localparam logic [5:0] OP_DIV   = 6'h17;
    localparam logic [5:0] OP_DIVU  = 6'h18;
    localparam logic [5:0] OP_MFHI  = 6'h19;
    localparam logic [5:0] OP_MFLO  = 6'h1A;
    localparam logic [5:0] OP_MTHI  = 6'h1B;
    localparam logic [5:0] OP_MTLO  = 6'h1C;

    // The counter is loaded with LAT-1 so that commit on cnt==0 lands exactly LAT busy cycles after issue.
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          age_q, age_d;
    logic          dz_q, dz_d;
    logic          seen_q, seen_d;
    logic          mt_age_q, mt_age_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic [31:0]   shadow_hi_q, shadow_hi_d;
    logic [31:0]   shadow_lo_q, shadow_lo_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          unit_start_q, unit_start_d;
    logic [1:0]    unit_op_q, unit_op_d;
    logic [31:0]   unit_a_q, unit_a_d;
    logic [31:0]   unit_b_q, unit_b_d;

    logic is_arith;
    logic is_mdu;
    logic is_div;

    assign is_arith = (bus.e_op >= OP_MULT) && (bus.e_op <= OP_DIVU);
    assign is_mdu   = (bus.e_op >= OP_MULT) && (bus.e_op <= OP_MTLO);
    assign is_div   = (bus.e_op == OP_DIV) || (bus.e_op == OP_DIVU);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        age_d        = age_q;
        dz_d         = dz_q;
        seen_d       = seen_q;
        mt_age_d     = 1'b0;
        pend_hi_d    = pend_hi_q;
        pend_lo_d    = pend_lo_q;
        shadow_hi_d  = shadow_hi_q;
        shadow_lo_d  = shadow_lo_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        unit_start_d = 1'b0;
        unit_op_d    = unit_op_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;

        // A flushed MTHI/MTLO from last cycle is undone from the shadow copy.
        if (bus.req && mt_age_q) begin
            hi_d = shadow_hi_q;
            lo_d = shadow_lo_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.e_valid && !bus.req) begin
                    if (is_arith) begin
                        state_d      = RUN;
                        unit_start_d = 1'b1;
                        unit_op_d    = 2'(bus.e_op - OP_MULT);
                        unit_a_d     = bus.e_rs;
                        unit_b_d     = bus.e_rt;
                        cnt_d        = is_div ? DIV_CNT : MUL_CNT;
                        age_d        = 1'b1;
                        seen_d       = 1'b0;
                        dz_d         = is_div && (bus.e_rt == 32'd0);
                    end else if (bus.e_op == OP_MTHI || bus.e_op == OP_MTLO) begin
                        shadow_hi_d = hi_q;
                        shadow_lo_d = lo_q;
                        mt_age_d    = 1'b1;
                        if (bus.e_op == OP_MTHI) hi_d = bus.e_rs;
                        else                     lo_d = bus.e_rs;
                    end
                end
            end
            RUN: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                age_d = 1'b0;
                if (bus.unit_done) begin
                    pend_hi_d = bus.unit_hi;
                    pend_lo_d = bus.unit_lo;
                    seen_d    = 1'b1;
                end
                // Only the issuing cycle's flush kills the op; later it has graduated past M.
                if (bus.req && age_q) begin
                    state_d = (seen_q || bus.unit_done) ? IDLE : DRAIN;
                end else if (cnt_q == '0 && (seen_q || bus.unit_done)) begin
                    if (!dz_q) begin
                        hi_d = bus.unit_done ? bus.unit_hi : pend_hi_q;
                        lo_d = bus.unit_done ? bus.unit_lo : pend_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (bus.unit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            age_q        <= 1'b0;
            dz_q         <= 1'b0;
            seen_q       <= 1'b0;
            mt_age_q     <= 1'b0;
            pend_hi_q    <= '0;
            pend_lo_q    <= '0;
            shadow_hi_q  <= '0;
            shadow_lo_q  <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            unit_start_q <= 1'b0;
            unit_op_q    <= '0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            age_q        <= age_d;
            dz_q         <= dz_d;
            seen_q       <= seen_d;
            mt_age_q     <= mt_age_d;
            pend_hi_q    <= pend_hi_d;
            pend_lo_q    <= pend_lo_d;
            shadow_hi_q  <= shadow_hi_d;
            shadow_lo_q  <= shadow_lo_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            unit_start_q <= unit_start_d;
            unit_op_q    <= unit_op_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
        end
    end

    assign bus.unit_start = unit_start_q;
    assign bus.unit_op    = unit_op_q;
    assign bus.unit_a     = unit_a_q;
    assign bus.unit_b     = unit_b_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.stall_e    = (state_q != IDLE) && bus.e_valid && is_mdu;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.rd_data    = (bus.e_op == OP_MFHI) ? hi_q :
                            (bus.e_op == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_sched.sv
// Directed, table-driven bench for mdu_sched: each table row is one cycle of inputs
// plus the outputs expected during that cycle, before its clock edge.
module tb_mdu_sched;
    localparam logic [5:0] NOP      = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h20;
    localparam logic [5:0] OP_MULT  = 6'h15;
    localparam logic [5:0] OP_MULTU = 6'h16;
    localparam logic [5:0] OP_DIV   = 6'h17;
    localparam logic [5:0] OP_DIVU  = 6'h18;
    localparam logic [5:0] OP_MFHI  = 6'h19;
    localparam logic [5:0] OP_MFLO  = 6'h1A;
    localparam logic [5:0] OP_MTHI  = 6'h1B;
    localparam logic [5:0] OP_MTLO  = 6'h1C;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mdu_sched_if bus();

    mdu_sched #(.MUL_LAT(5), .DIV_LAT(10), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ev;
        logic [5:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        rq;
        logic        dn;
        logic [31:0] uhi;
        logic [31:0] ulo;
        logic        x_start;
        logic        x_busy;
        logic        x_stall;
        logic [31:0] x_rd;
        logic [31:0] x_hi;
        logic [31:0] x_lo;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    task automatic add(input logic ev, input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rq, input logic dn, input logic [31:0] uhi, input logic [31:0] ulo,
                       input logic xs, input logic xb, input logic xst, input logic [31:0] xrd,
                       input logic [31:0] xhi, input logic [31:0] xlo);
        vec_t v;
        v.ev = ev; v.op = op; v.rs = rs; v.rt = rt; v.rq = rq; v.dn = dn; v.uhi = uhi; v.ulo = ulo;
        v.x_start = xs; v.x_busy = xb; v.x_stall = xst; v.x_rd = xrd; v.x_hi = xhi; v.x_lo = xlo;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic xs, input logic xb, input logic [31:0] xhi, input logic [31:0] xlo);
        add(1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, xs, xb, 1'b0, 32'd0, xhi, xlo);
    endtask

    task automatic apply_stimulus(input logic ev, input logic [5:0] op, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic rq, input logic dn,
                                  input logic [31:0] uhi, input logic [31:0] ulo);
        @(negedge clk);
        bus.e_valid   = ev;
        bus.e_op      = op;
        bus.e_rs      = rs;
        bus.e_rt      = rt;
        bus.req       = rq;
        bus.unit_done = dn;
        bus.unit_hi   = uhi;
        bus.unit_lo   = ulo;
        #1;
    endtask

    task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic nop_cycle();
        apply_stimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.e_valid = 1'b0; bus.e_op = NOP; bus.e_rs = '0; bus.e_rt = '0;
        bus.req = 1'b0; bus.unit_done = 1'b0; bus.unit_hi = '0; bus.unit_lo = '0;

        // Reset state, then MULT 3 * -2 with done at cycle 2 and a stalled MFLO behind it.
        idle(0, 0, 32'h0, 32'h0);
        add(1, OP_MULT, 32'd3, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        add(1, OP_MFLO, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h0);
        add(1, OP_MFLO, 0, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 1, 1, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            add(1, OP_MFLO, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0);
        add(1, OP_MFLO, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA);
        add(0, NOP, 0, 0, 0, 1, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);

        // DIVU 7/2 with a late done at cycle 14; non-MDU op never stalls, req after age is ignored.
        add(1, OP_DIVU, 32'd7, 32'd2, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        idle(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        add(1, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        add(0, NOP, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        for (int i = 4; i <= 13; i++) idle(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        add(0, NOP, 0, 0, 0, 1, 32'd1, 32'd3, 0, 1, 0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        add(1, OP_MFHI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'd1, 32'd3);

        // DIV by zero: 10 busy cycles, result suppressed.
        add(1, OP_DIV, 32'd5, 32'd0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'd1, 32'd3);
        idle(1, 1, 32'd1, 32'd3);
        idle(0, 1, 32'd1, 32'd3);
        add(0, NOP, 0, 0, 0, 1, 32'hDEAD, 32'hBEEF, 0, 1, 0, 32'h0, 32'd1, 32'd3);
        for (int i = 4; i <= 10; i++) idle(0, 1, 32'd1, 32'd3);
        idle(0, 0, 32'd1, 32'd3);

        // DIV flushed in its first RUN cycle: drain until done at cycle 6, then a normal MULT.
        add(1, OP_DIV, 32'd100, 32'd7, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'd1, 32'd3);
        add(0, NOP, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0, 32'd1, 32'd3);
        idle(0, 1, 32'd1, 32'd3);
        add(1, OP_MFHI, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'd1, 32'd1, 32'd3);
        idle(0, 1, 32'd1, 32'd3);
        idle(0, 1, 32'd1, 32'd3);
        add(0, NOP, 0, 0, 0, 1, 32'd55, 32'd66, 0, 1, 0, 32'h0, 32'd1, 32'd3);
        add(1, OP_MULT, 32'd2, 32'd3, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'd1, 32'd3);
        idle(1, 1, 32'd1, 32'd3);
        for (int i = 2; i <= 4; i++) idle(0, 1, 32'd1, 32'd3);
        add(0, NOP, 0, 0, 0, 1, 32'd0, 32'd6, 0, 1, 0, 32'h0, 32'd1, 32'd3);
        idle(0, 0, 32'd0, 32'd6);

        // MTHI rollback on req the next cycle, then the same without req, then MTLO.
        add(1, OP_MTHI, 32'hAAAA, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'd0, 32'd6);
        idle(0, 0, 32'hAAAA, 32'd6);
        add(1, OP_MTHI, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hAAAA, 32'd6);
        add(0, NOP, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h1234, 32'd6);
        idle(0, 0, 32'hAAAA, 32'd6);
        add(1, OP_MTHI, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hAAAA, 32'd6);
        idle(0, 0, 32'h1234, 32'd6);
        idle(0, 0, 32'h1234, 32'd6);
        add(1, OP_MTLO, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h1234, 32'd6);
        idle(0, 0, 32'h1234, 32'h77);

        // MULT flushed in E the same cycle it is presented never issues.
        add(1, OP_MULT, 32'd5, 32'd5, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h1234, 32'h77);
        idle(0, 0, 32'h1234, 32'h77);
        idle(0, 0, 32'h1234, 32'h77);

        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].ev, vecs[i].op, vecs[i].rs, vecs[i].rt,
                           vecs[i].rq, vecs[i].dn, vecs[i].uhi, vecs[i].ulo);
            check_output($sformatf("vec%0d", i),
                         128'({bus.unit_start, bus.busy, bus.stall_e, bus.rd_data, bus.hi, bus.lo}),
                         128'({vecs[i].x_start, vecs[i].x_busy, vecs[i].x_stall,
                               vecs[i].x_rd, vecs[i].x_hi, vecs[i].x_lo}));
        end

        // MULTU: launch operands and op code, then commit with done on the last busy cycle.
        apply_stimulus(1'b1, OP_MULTU, 32'h00010001, 32'h00030000, 1'b0, 1'b0, 32'd0, 32'd0);
        nop_cycle();
        check_output("multu_start", 128'(bus.unit_start), 128'(1'b1));
        check_output("multu_op", 128'(bus.unit_op), 128'(2'd1));
        check_output("multu_a", 128'(bus.unit_a), 128'(32'h00010001));
        check_output("multu_b", 128'(bus.unit_b), 128'(32'h00030000));
        nop_cycle();
        check_output("multu_start_pulse", 128'(bus.unit_start), 128'(1'b0));
        nop_cycle();
        nop_cycle();
        apply_stimulus(1'b0, NOP, 32'd0, 32'd0, 1'b0, 1'b1, 32'd3, 32'h00030000);
        check_output("multu_busy5", 128'(bus.busy), 128'(1'b1));
        nop_cycle();
        check_output("multu_commit", 128'({bus.busy, bus.hi, bus.lo}),
                     128'({1'b0, 32'd3, 32'h00030000}));

        // DIVU abandoned by reset mid-RUN.
        apply_stimulus(1'b1, OP_DIVU, 32'h11, 32'h22, 1'b0, 1'b0, 32'd0, 32'd0);
        nop_cycle();
        check_output("divu_launch", 128'({bus.unit_op, bus.unit_a, bus.unit_b}),
                     128'({2'd3, 32'h11, 32'h22}));
        nop_cycle();
        reset = 1'b1;
        nop_cycle();
        reset = 1'b0;
        check_output("reset_mid_run",
                     128'({bus.busy, bus.unit_start, bus.unit_op, bus.unit_a, bus.hi, bus.lo}),
                     128'({1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0}));
        nop_cycle();
        check_output("reset_idle_hold", 128'({bus.busy, bus.unit_b}), 128'({1'b0, 32'd0}));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
